// File: rtl/miriscv_pkg.sv
// Shared core parameters and types.
// Includes the instruction-memory bridge FSM states.
package miriscv_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        IMB_IDLE   = 2'd0,
        IMB_ACTIVE = 2'd1,
        IMB_FLUSH  = 2'd2
    } imb_state_e;

endpackage

// File: rtl/miriscv_instr_mem_bridge.sv
// Fetch port to pipelined req/gnt/rvalid instruction bus bridge.
// Tracks outstanding transactions and drops responses of killed fetches.
module miriscv_instr_mem_bridge
    import miriscv_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic            clk_i,
    input  logic            arstn_i,
    input  logic            flush_i,
    input  logic            core_req_i,
    input  logic [XLEN-1:0] core_addr_i,
    output logic            core_rvalid_o,
    output logic [XLEN-1:0] core_rdata_o,
    output logic            busy_o,
    output logic            err_o,
    output logic            mem_req_o,
    output logic [XLEN-1:0] mem_addr_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ZERO_C = '0;
    localparam logic [CW-1:0] ONE_C = CW'(1);

    imb_state_e    state_q, state_d;
    logic [CW-1:0] out_cnt_q, out_cnt_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;
    logic [CW-1:0] cnt_upd;
    logic          err_q;
    logic          accept;
    logic          rsp;
    logic          in_flush;

    assign in_flush = (state_q == IMB_FLUSH);
    assign accept   = mem_req_o & mem_gnt_i;
    // Only responses with something outstanding are counted.
    assign rsp      = mem_rvalid_i & (out_cnt_q != ZERO_C);
    assign cnt_upd  = out_cnt_q + CW'(accept) - CW'(rsp);

    assign mem_req_o  = core_req_i & (out_cnt_q < DEPTH_C) & ~in_flush;
    assign mem_addr_o = core_addr_i;
    assign busy_o     = (core_req_i & ~accept) | in_flush;

    // A response landing in the flush cycle belongs to a killed fetch.
    assign core_rvalid_o = mem_rvalid_i & (drop_cnt_q == ZERO_C)
                         & (out_cnt_q != ZERO_C) & ~flush_i;
    assign core_rdata_o  = mem_rdata_i;
    assign err_o         = err_q;

    always_comb begin
        state_d    = state_q;
        out_cnt_d  = cnt_upd;
        drop_cnt_d = drop_cnt_q;
        unique case (state_q)
            IMB_FLUSH: begin
                if (rsp) begin
                    drop_cnt_d = drop_cnt_q - ONE_C;
                end
                if (drop_cnt_d == ZERO_C) begin
                    state_d = (cnt_upd != ZERO_C) ? IMB_ACTIVE : IMB_IDLE;
                end
            end
            default: begin
                if (flush_i && cnt_upd != ZERO_C) begin
                    drop_cnt_d = cnt_upd;
                    state_d    = IMB_FLUSH;
                end else if (flush_i) begin
                    state_d = IMB_IDLE;
                end else begin
                    state_d = (cnt_upd != ZERO_C) ? IMB_ACTIVE : IMB_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q    <= IMB_IDLE;
            out_cnt_q  <= '0;
            drop_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            out_cnt_q  <= out_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            if (mem_rvalid_i && out_cnt_q == ZERO_C) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_miriscv_instr_mem_bridge.sv
// Directed self-checking bench for miriscv_instr_mem_bridge.
// Inputs change 1ns after the rising edge; checks sample 2ns later.
module tb_miriscv_instr_mem_bridge;
    import miriscv_pkg::*;

    logic            clk;
    logic            arstn;
    logic            flush;
    logic            core_req;
    logic [XLEN-1:0] core_addr;
    logic            core_rvalid;
    logic [XLEN-1:0] core_rdata;
    logic            busy;
    logic            err;
    logic            mem_req;
    logic [XLEN-1:0] mem_addr;
    logic            mem_gnt;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;

    int nchecks = 0;
    int nerrors = 0;

    miriscv_instr_mem_bridge #(.DEPTH(2)) dut (
        .clk_i        (clk),
        .arstn_i      (arstn),
        .flush_i      (flush),
        .core_req_i   (core_req),
        .core_addr_i  (core_addr),
        .core_rvalid_o(core_rvalid),
        .core_rdata_o (core_rdata),
        .busy_o       (busy),
        .err_o        (err),
        .mem_req_o    (mem_req),
        .mem_addr_o   (mem_addr),
        .mem_gnt_i    (mem_gnt),
        .mem_rvalid_i (mem_rvalid),
        .mem_rdata_i  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerrors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic req, input logic [31:0] addr,
                       input logic gnt, input logic rv,
                       input logic [31:0] rd, input logic fl);
        core_req   = req;
        core_addr  = addr;
        mem_gnt    = gnt;
        mem_rvalid = rv;
        mem_rdata  = rd;
        flush      = fl;
        #2;
    endtask

    function automatic logic [31:0] st(input imb_state_e s);
        return 32'(s);
    endfunction

    initial begin
        arstn = 1'b0;
        drv(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("rst_mem_req", 32'(mem_req), 32'd1);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_rvalid", 32'(core_rvalid), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_out_cnt", 32'(dut.out_cnt_q), 32'd0);
        chk("rst_drop_cnt", 32'(dut.drop_cnt_q), 32'd0);
        chk("rst_state", 32'(dut.state_q), st(IMB_IDLE));
        drv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        arstn = 1'b1;
        tick();

        // zero-wait stream
        drv(1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("zw0_busy", 32'(busy), 32'd0);
        chk("zw0_addr", mem_addr, 32'h0);
        tick();
        drv(1'b1, 32'h4, 1'b1, 1'b1, 32'h1000, 1'b0);
        chk("zw1_busy", 32'(busy), 32'd0);
        chk("zw1_rvalid", 32'(core_rvalid), 32'd1);
        chk("zw1_rdata", core_rdata, 32'h1000);
        tick();
        drv(1'b1, 32'h8, 1'b1, 1'b1, 32'h1004, 1'b0);
        chk("zw2_out_cnt_same", 32'(dut.out_cnt_q), 32'd1);
        chk("zw2_busy", 32'(busy), 32'd0);
        chk("zw2_rdata", core_rdata, 32'h1004);
        tick();
        drv(1'b0, 32'h0, 1'b0, 1'b1, 32'h1008, 1'b0);
        chk("zw3_rvalid", 32'(core_rvalid), 32'd1);
        chk("zw3_rdata", core_rdata, 32'h1008);
        chk("zw3_busy", 32'(busy), 32'd0);
        tick();
        drv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("zw_out_cnt_end", 32'(dut.out_cnt_q), 32'd0);

        // grant stall
        for (int i = 0; i < 3; i++) begin
            drv(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0);
            chk("gs_busy", 32'(busy), 32'd1);
            chk("gs_req", 32'(mem_req), 32'd1);
            chk("gs_addr", mem_addr, 32'h100);
            tick();
        end
        drv(1'b1, 32'h100, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("gs_accept_busy", 32'(busy), 32'd0);
        tick();
        drv(1'b0, 32'h0, 1'b0, 1'b1, 32'h2000, 1'b0);
        chk("gs_rvalid", 32'(core_rvalid), 32'd1);
        chk("gs_rdata", core_rdata, 32'h2000);
        tick();

        // outstanding limit
        drv(1'b1, 32'h10, 1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        drv(1'b1, 32'h14, 1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        drv(1'b1, 32'h18, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("ol_out_cnt", 32'(dut.out_cnt_q), 32'd2);
        chk("ol_req0", 32'(mem_req), 32'd0);
        chk("ol_busy0", 32'(busy), 32'd1);
        tick();
        drv(1'b1, 32'h18, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("ol_req1", 32'(mem_req), 32'd0);
        tick();
        drv(1'b1, 32'h18, 1'b1, 1'b1, 32'h3000, 1'b0);
        chk("ol_rsp_rvalid", 32'(core_rvalid), 32'd1);
        chk("ol_rsp_req", 32'(mem_req), 32'd0);
        chk("ol_rsp_busy", 32'(busy), 32'd1);
        tick();
        drv(1'b1, 32'h18, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("ol_after_req", 32'(mem_req), 32'd1);
        chk("ol_after_busy", 32'(busy), 32'd0);
        tick();
        drv(1'b0, 32'h0, 1'b0, 1'b1, 32'h3004, 1'b0);
        chk("ol_d1_rdata", core_rdata, 32'h3004);
        tick();
        drv(1'b0, 32'h0, 1'b0, 1'b1, 32'h3008, 1'b0);
        chk("ol_d2_rvalid", 32'(core_rvalid), 32'd1);
        tick();
        drv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("ol_out_cnt_end", 32'(dut.out_cnt_q), 32'd0);

        // flush drop
        drv(1'b1, 32'h20, 1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        drv(1'b1, 32'h24, 1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        drv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        drv(1'b1, 32'h200, 1'b1, 1'b1, 32'hDEAD, 1'b0);
        chk("fd_state", 32'(dut.state_q), st(IMB_FLUSH));
        chk("fd_drop_cnt", 32'(dut.drop_cnt_q), 32'd2);
        chk("fd_dead_rvalid", 32'(core_rvalid), 32'd0);
        chk("fd_dead_req", 32'(mem_req), 32'd0);
        chk("fd_dead_busy", 32'(busy), 32'd1);
        tick();
        drv(1'b1, 32'h200, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("fd_gap_busy", 32'(busy), 32'd1);
        tick();
        drv(1'b1, 32'h200, 1'b1, 1'b1, 32'hBEEF, 1'b0);
        chk("fd_beef_rvalid", 32'(core_rvalid), 32'd0);
        chk("fd_beef_busy", 32'(busy), 32'd1);
        tick();
        drv(1'b1, 32'h200, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("fd_exit_req", 32'(mem_req), 32'd1);
        chk("fd_exit_busy", 32'(busy), 32'd0);
        chk("fd_exit_addr", mem_addr, 32'h200);
        tick();
        drv(1'b0, 32'h0, 1'b0, 1'b1, 32'h5000, 1'b0);
        chk("fd_new_rvalid", 32'(core_rvalid), 32'd1);
        chk("fd_new_rdata", core_rdata, 32'h5000);
        tick();

        // flush coinciding with a response
        drv(1'b1, 32'h30, 1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        drv(1'b1, 32'h34, 1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        drv(1'b0, 32'h0, 1'b0, 1'b1, 32'h6000, 1'b1);
        chk("sf_rvalid", 32'(core_rvalid), 32'd0);
        tick();
        drv(1'b0, 32'h0, 1'b0, 1'b1, 32'h6004, 1'b0);
        chk("sf_drop_cnt", 32'(dut.drop_cnt_q), 32'd1);
        chk("sf_out_cnt", 32'(dut.out_cnt_q), 32'd1);
        chk("sf_drop_rvalid", 32'(core_rvalid), 32'd0);
        tick();
        drv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("sf_state_end", 32'(dut.state_q), st(IMB_IDLE));
        chk("sf_err_clean", 32'(err), 32'd0);

        // protocol error
        drv(1'b0, 32'h0, 1'b0, 1'b1, 32'h7000, 1'b0);
        chk("pe_rvalid", 32'(core_rvalid), 32'd0);
        tick();
        drv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("pe_err_set", 32'(err), 32'd1);
        tick();
        chk("pe_err_sticky", 32'(err), 32'd1);

        // reset mid-burst
        drv(1'b1, 32'h40, 1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        drv(1'b1, 32'h44, 1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        drv(1'b1, 32'h48, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("mr_out_cnt_pre", 32'(dut.out_cnt_q), 32'd2);
        arstn = 1'b0;
        #1;
        chk("mr_out_cnt", 32'(dut.out_cnt_q), 32'd0);
        chk("mr_drop_cnt", 32'(dut.drop_cnt_q), 32'd0);
        chk("mr_err", 32'(err), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        tick();
        drv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        arstn = 1'b1;
        tick();
        drv(1'b0, 32'h0, 1'b0, 1'b1, 32'h8000, 1'b0);
        tick();
        drv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("mr_stale_err", 32'(err), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors",
                 nchecks, nerrors);
        $finish;
    end

endmodule

// File: doc/miriscv_instr_mem_bridge.md
# miriscv_instr_mem_bridge

Bridges the fetch stage's single-cycle instruction port onto a pipelined req/gnt/rvalid instruction bus with variable grant and response latency. It sits directly upstream of the fetch unit.
- Each cycle it either completes the fetch request or raises `busy_o`, which the control unit ORs into the fetch stall.
- It tracks up to DEPTH outstanding bus transactions.
- It discards the responses of killed fetches after a pipeline flush.

## Interface
- `DEPTH`, default 2: maximum number of outstanding bus transactions; a power of two, at least 2.
- `clk_i`  in  1  core clock
- `arstn_i`  in  1  reset; asynchronous, active-low
- `flush_i`  in  1  kill of in-flight fetches; driven by the control unit's fetch-kill
- `core_req_i`  in  1  fetch request; the address is held stable until the request is accepted
- `core_addr_i`  in  XLEN  fetch address, word aligned
- `core_rvalid_o`  out  1  instruction valid
- `core_rdata_o`  out  XLEN  instruction word
- `busy_o`  out  1  stall request to the control unit
- `err_o`  out  1  sticky protocol-error flag
- `mem_req_o`  out  1  bus request
- `mem_addr_o`  out  XLEN  bus address
- `mem_gnt_i`  in  1  bus grant; a transaction is accepted when `mem_req_o & mem_gnt_i`
- `mem_rvalid_i`  in  1  bus response valid; responses return in order
- `mem_rdata_i`  in  XLEN  bus response data

## Operation
- FSM has three states:
  - IDLE: no outstanding transactions.
  - ACTIVE: `out_cnt` > 0, responses are delivered to the core.
  - FLUSH: discarding responses of killed transactions.
- `out_cnt` counts outstanding transactions. Width is `$clog2(DEPTH+1)`.
  - +1 on accept, −1 on each counted response.
  - Accept and response in the same cycle leave it unchanged.
- `drop_cnt` counts responses still to be discarded. Same width as `out_cnt`.
- Request path (IDLE/ACTIVE):
  - `mem_req_o = core_req_i & (out_cnt < DEPTH)`.
  - `mem_addr_o = core_addr_i`.
- `busy_o = (core_req_i & ~(mem_req_o & mem_gnt_i)) | (state == FLUSH)`.
- Response path:
  - `core_rvalid_o = mem_rvalid_i & (drop_cnt == 0) & (out_cnt != 0)`.
  - `core_rdata_o = mem_rdata_i`.
- Flush handling:
  - When `flush_i` is high and `out_cnt` is nonzero after this cycle's update: `drop_cnt` loads that value and the FSM enters FLUSH.
  - When `flush_i` is high and no transaction is left: the FSM goes to IDLE.
  - The same-cycle response is still counted and is suppressed from the core.
  - A request accepted in the flush cycle is counted as killed.
- FLUSH:
  - `mem_req_o` = 0.
  - Each `mem_rvalid_i` decrements both `drop_cnt` and `out_cnt`.
  - When `drop_cnt` reaches 0, the FSM goes to IDLE.
  - `flush_i` while in FLUSH has no extra effect.
- Protocol error:
  - `mem_rvalid_i` while `out_cnt == 0` sets `err_o`.
  - The response is ignored.
  - `err_o` clears only on reset.

## Timing
- Reset state: FSM in IDLE, `out_cnt` = 0, `drop_cnt` = 0, `err_o` = 0.
- Reset values of the other outputs:
  - `mem_req_o` follows `core_req_i`.
  - `core_rvalid_o` = 0 unless `mem_rvalid_i` is high.
  - `busy_o` = `core_req_i`.
- Combinational paths, zero added latency:
  - `core_req_i`/`core_addr_i` to `mem_req_o`/`mem_addr_o`.
  - `mem_rvalid_i`/`mem_rdata_i` to `core_rvalid_o`/`core_rdata_o`.
- With a zero-wait memory (grant in the same cycle, rvalid on the next cycle):
  - No `busy_o`.
  - The fetch unit sees a one-cycle-latency memory.
- FLUSH exit: requests are accepted again in the cycle after the last dropped response.
- Reset mid-operation:
  - All counters clear immediately.
  - The bus must not return responses for pre-reset transactions. If it does, `err_o` is set.

## Structure
- `XLEN` comes from `miriscv_pkg`.
- Add the FSM state enum `imb_state_e` (IDLE/ACTIVE/FLUSH) to `miriscv_pkg`.
- Single module; no sub-modules.
- Both counters are local, with `$clog2`-derived widths.

## Test plan
- **Zero-wait stream.** `gnt` always 1, rvalid one cycle after accept, addresses 0x0, 0x4, 0x8 → three `core_rvalid_o` pulses in order; `busy_o` never 1.
- **Grant stall.** `gnt` = 0 for 3 cycles on addr 0x100 → `busy_o` = 1 for 3 cycles, `mem_addr_o` stable at 0x100, accepted on cycle 4.
- **Outstanding limit.** DEPTH = 2, two requests granted, no responses → third request has `mem_req_o` = 0 and `busy_o` = 1 until the first rvalid arrives.
- **Flush drop.**
  - Stimulus: two outstanding requests, then `flush_i`.
  - Response: the next two rvalids (data 0xDEAD, 0xBEEF) produce no `core_rvalid_o`; `busy_o` = 1 until then; the following request at 0x200 is delivered normally.
- **Simultaneous events.**
  - Accept and response in the same cycle → `out_cnt` unchanged.
  - Flush coinciding with a response, one more outstanding → that response is suppressed and `drop_cnt` = 1.
- **Error and reset.**
  - rvalid with nothing outstanding → `err_o` = 1 and stays high.
  - Reset asserted mid-burst → all counters 0 and `err_o` = 0 during reset.
